// File: rtl/serial_compare_accumulator.sv
`timescale 1ns / 1ps
// serial_compare_accumulator
//
// Accumulates a word comparison from a stream of per-digit results produced
// MSB-first by an upstream 2-bit comparator. The first unequal digit decides
// gt/lt; if every digit is equal the word is equal. Digits whose flags are not
// exactly one-hot raise a sticky err and are otherwise ignored.
//
// Ports:
//   clk          clock, all state updates on the rising edge
//   rst_n        asynchronous active-low reset
//   start        begin a new comparison (sampled only when idle)
//   digit_valid  upstream presents one digit result this cycle
//   digit_gt/lt/eq  per-digit flags (x greater / less / equal)
//   digit_ready  block accepts a digit this cycle
//   busy         comparison in progress or result being reported
//   done         one-cycle pulse when the result becomes valid
//   res_gt/lt/eq final word comparison, x vs y (held until the next start)
//   err          a non-one-hot digit was accepted in the last comparison
module serial_compare_accumulator #(
  parameter int unsigned NUM_DIGITS = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic digit_valid,
  input  logic digit_gt,
  input  logic digit_lt,
  input  logic digit_eq,
  output logic digit_ready,
  output logic busy,
  output logic done,
  output logic res_gt,
  output logic res_lt,
  output logic res_eq,
  output logic err
);

  localparam int unsigned CntW = $clog2(NUM_DIGITS + 1);
  localparam logic [CntW-1:0] LastIdx = CntW'(NUM_DIGITS - 1);

  typedef enum logic [1:0] {
    StIdle,
    StAccum,
    StDone
  } state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              decided_q, decided_d;
  logic              res_gt_q, res_gt_d;
  logic              res_lt_q, res_lt_d;
  logic              res_eq_q, res_eq_d;
  logic              err_q, err_d;

  logic              digit_accept;
  logic              flags_onehot;

  assign digit_ready  = (state_q == StAccum);
  assign busy         = (state_q != StIdle);
  assign done         = (state_q == StDone);
  assign digit_accept = digit_valid & digit_ready;

  assign flags_onehot = ( digit_gt & ~digit_lt & ~digit_eq) |
                        (~digit_gt &  digit_lt & ~digit_eq) |
                        (~digit_gt & ~digit_lt &  digit_eq);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    decided_d = decided_q;
    res_gt_d  = res_gt_q;
    res_lt_d  = res_lt_q;
    res_eq_d  = res_eq_q;
    err_d     = err_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d   = StAccum;
          cnt_d     = '0;
          decided_d = 1'b0;
          res_gt_d  = 1'b0;
          res_lt_d  = 1'b0;
          res_eq_d  = 1'b0;
          err_d     = 1'b0;
        end
      end

      StAccum: begin
        if (digit_accept) begin
          cnt_d = cnt_q + CntW'(1);
          if (!flags_onehot) begin
            err_d = 1'b1;
          end else if (!decided_q) begin
            // First unequal digit decides; later digits are only counted.
            if (digit_gt) begin
              res_gt_d  = 1'b1;
              decided_d = 1'b1;
            end else if (digit_lt) begin
              res_lt_d  = 1'b1;
              decided_d = 1'b1;
            end
          end
          if (cnt_q == LastIdx) begin
            state_d = StDone;
            // Use the post-update decision so a deciding last digit wins.
            if (!decided_d) begin
              res_eq_d = 1'b1;
            end
          end
        end
      end

      StDone: begin
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      decided_q <= 1'b0;
      res_gt_q  <= 1'b0;
      res_lt_q  <= 1'b0;
      res_eq_q  <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      decided_q <= decided_d;
      res_gt_q  <= res_gt_d;
      res_lt_q  <= res_lt_d;
      res_eq_q  <= res_eq_d;
      err_q     <= err_d;
    end
  end

  assign res_gt = res_gt_q;
  assign res_lt = res_lt_q;
  assign res_eq = res_eq_q;
  assign err    = err_q;

endmodule

// File: tb/tb_serial_compare_accumulator.sv
`timescale 1ns / 1ps
// Directed bench for serial_compare_accumulator with NUM_DIGITS = 4.
// Inputs change and outputs are checked on the falling clock edge.
module tb_serial_compare_accumulator;

  logic clk = 1'b0;
  logic rst_n;
  logic start;
  logic digit_valid;
  logic digit_gt;
  logic digit_lt;
  logic digit_eq;
  logic digit_ready;
  logic busy;
  logic done;
  logic res_gt;
  logic res_lt;
  logic res_eq;
  logic err;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  serial_compare_accumulator #(
    .NUM_DIGITS(4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .digit_valid(digit_valid),
    .digit_gt   (digit_gt),
    .digit_lt   (digit_lt),
    .digit_eq   (digit_eq),
    .digit_ready(digit_ready),
    .busy       (busy),
    .done       (done),
    .res_gt     (res_gt),
    .res_lt     (res_lt),
    .res_eq     (res_eq),
    .err        (err)
  );

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Check every output: ready, busy, done, res_gt, res_lt, res_eq, err.
  task automatic chk_all(input string tag, input logic e_rdy, input logic e_bsy,
                         input logic e_dn, input logic e_gt, input logic e_lt,
                         input logic e_eq, input logic e_err);
    chk({tag, ".digit_ready"}, digit_ready, e_rdy);
    chk({tag, ".busy"},        busy,        e_bsy);
    chk({tag, ".done"},        done,        e_dn);
    chk({tag, ".res_gt"},      res_gt,      e_gt);
    chk({tag, ".res_lt"},      res_lt,      e_lt);
    chk({tag, ".res_eq"},      res_eq,      e_eq);
    chk({tag, ".err"},         err,         e_err);
  endtask

  // Present one digit (flags gt,lt,eq) for one clock; valid left asserted.
  task automatic dig(input logic g, input logic l, input logic e);
    digit_valid = 1'b1;
    digit_gt    = g;
    digit_lt    = l;
    digit_eq    = e;
    @(negedge clk);
  endtask

  task automatic idle_in();
    digit_valid = 1'b0;
    digit_gt    = 1'b0;
    digit_lt    = 1'b0;
    digit_eq    = 1'b0;
    start       = 1'b0;
  endtask

  // Pulse start for one cycle from IDLE; returns in ACCUM.
  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    idle_in();
    @(negedge clk);
    chk_all("reset", 0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk_all("idle", 0, 0, 0, 0, 0, 0, 0);

    // x=0xB4 y=0xB1: eq,eq,gt,lt back-to-back -> gt
    do_start();
    chk_all("t1.accum", 1, 1, 0, 0, 0, 0, 0);
    dig(0, 0, 1);
    chk_all("t1.d1", 1, 1, 0, 0, 0, 0, 0);
    dig(0, 0, 1);
    chk_all("t1.d2", 1, 1, 0, 0, 0, 0, 0);
    dig(1, 0, 0);
    chk_all("t1.d3", 1, 1, 0, 1, 0, 0, 0);
    dig(0, 1, 0);
    idle_in();
    chk_all("t1.done", 0, 1, 1, 1, 0, 0, 0);
    @(negedge clk);
    chk_all("t1.after", 0, 0, 0, 1, 0, 0, 0);

    // x=y=0x5A: four eq digits -> eq, held through idle (valid ignored)
    do_start();
    chk_all("t2.accum", 1, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      chk("t2.nodone", done, 1'b0);
      dig(0, 0, 1);
    end
    idle_in();
    chk_all("t2.done", 0, 1, 1, 0, 0, 1, 0);
    for (int i = 0; i < 5; i++) begin
      digit_valid = 1'b1;
      digit_gt    = 1'b1;
      @(negedge clk);
      chk_all("t2.hold", 0, 0, 0, 0, 0, 1, 0);
    end
    idle_in();

    // x=0x3F y=0xC0: lt,gt,gt,gt with 3-cycle gaps -> lt
    do_start();
    for (int d = 0; d < 4; d++) begin
      if (d == 0) dig(0, 1, 0);
      else        dig(1, 0, 0);
      if (d < 3) begin
        for (int g = 0; g < 3; g++) begin
          digit_valid = 1'b0;
          digit_gt    = 1'b1;
          @(negedge clk);
          chk_all("t3.gap", 1, 1, 0, 0, 1, 0, 0);
        end
      end
    end
    idle_in();
    chk_all("t3.done", 0, 1, 1, 0, 1, 0, 0);
    @(negedge clk);

    // 2nd digit gt=lt=1 -> err sticky; res decided by later gt
    do_start();
    dig(0, 0, 1);
    dig(1, 1, 0);
    chk_all("t4.errdig", 1, 1, 0, 0, 0, 0, 1);
    dig(1, 0, 0);
    chk_all("t4.d3", 1, 1, 0, 1, 0, 0, 1);
    dig(0, 0, 1);
    idle_in();
    chk_all("t4.done", 0, 1, 1, 1, 0, 0, 1);
    @(negedge clk);
    chk_all("t4.idle", 0, 0, 0, 1, 0, 0, 1);

    // Next start clears err; start during ACCUM and DONE is ignored
    do_start();
    chk_all("t5.cleared", 1, 1, 0, 0, 0, 0, 0);
    dig(0, 0, 1);
    start = 1'b1;
    dig(0, 0, 1);
    chk_all("t5.d2", 1, 1, 0, 0, 0, 0, 0);
    dig(0, 0, 1);
    chk_all("t5.d3", 1, 1, 0, 0, 0, 0, 0);
    start = 1'b0;
    dig(0, 0, 1);
    idle_in();
    chk_all("t5.done", 0, 1, 1, 0, 0, 1, 0);
    start = 1'b1;
    @(negedge clk);
    chk_all("t5.doneign", 0, 0, 0, 0, 0, 1, 0);
    @(negedge clk);
    start = 1'b0;
    chk_all("t5.restart", 1, 1, 0, 0, 0, 0, 0);

    // Reset after two accepted digits -> outputs clear at once, no done
    dig(0, 0, 1);
    dig(1, 0, 0);
    idle_in();
    chk_all("t6.pre", 1, 1, 0, 1, 0, 0, 0);
    #2 rst_n = 1'b0;
    #1 chk_all("t6.async", 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk_all("t6.inrst", 0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk_all("t6.nodone", 0, 0, 0, 0, 0, 0, 0);
    do_start();
    dig(0, 0, 1);
    dig(0, 0, 1);
    dig(0, 0, 1);
    chk_all("t6.d3", 1, 1, 0, 0, 0, 0, 0);
    dig(1, 0, 0);
    idle_in();
    chk_all("t6.done", 0, 1, 1, 1, 0, 0, 0);
    @(negedge clk);
    chk_all("t6.idle", 0, 0, 0, 1, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
